nx_sim_ctrl: RTL and testbench

Multi-mesh simulation sequencer. Generates the per-cycle trigger pulse for up to MESHES independent meshes and maintains the simulated-cycle counter. Supports free-run, N-step and stop modes through a command port. Sits at the accelerator top between the host control interface and the nx_mesh instances, replacing the single-mesh fixed trigger loop.

---
 rtl/nx_ctrl_pkg.sv | 27 ++
 rtl/nx_ctrl_watchdog.sv | 36 +++
 rtl/nx_sim_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_nx_sim_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nx_ctrl_pkg.sv
// Shared types for the multi-mesh simulation sequencer: command ops, FSM states and run modes.
// The optional watchdog is enabled by defining NX_SIM_CTRL_WDOG_EN.
package nx_ctrl_pkg;

    typedef enum logic [1:0] {
        NX_CTRL_NOP  = 2'd0,
        NX_CTRL_RUN  = 2'd1,
        NX_CTRL_STEP = 2'd2,
        NX_CTRL_STOP = 2'd3
    } nx_op_e;

    typedef enum logic [1:0] {
        StStop     = 2'd0,
        StWaitIdle = 2'd1,
        StWaitBusy = 2'd2
    } nx_state_e;

    typedef enum logic {
        ModeRun  = 1'b0,
        ModeStep = 1'b1
    } nx_mode_e;

    function automatic logic nx_is_start(nx_op_e op);
        return (op == NX_CTRL_RUN) || (op == NX_CTRL_STEP);
    endfunction

endpackage

// File: rtl/nx_ctrl_watchdog.sv
// Cycle watchdog for nx_sim_ctrl; instantiated only when NX_SIM_CTRL_WDOG_EN is defined.
// A zero limit disables the timeout.
module nx_ctrl_watchdog #(
    parameter int unsigned WDOG_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [WDOG_WIDTH-1:0] limit,
    output logic                  timeout
);

    logic [WDOG_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + WDOG_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Deliberately independent of clear to avoid a loop through the trigger decision.
    assign timeout = enable && (limit != '0) && (cnt_q == limit);

endmodule

// File: rtl/nx_sim_ctrl.sv
// Multi-mesh simulation sequencer: per-mesh trigger pulses, cycle counter, RUN/STEP/STOP control.
// Define NX_SIM_CTRL_WDOG_EN to add the stall watchdog (error_o); otherwise error_o is tied low.
module nx_sim_ctrl
    import nx_ctrl_pkg::*;
#(
    parameter int unsigned MESHES        = 4,
    parameter int unsigned COUNTER_WIDTH = 32,
    parameter int unsigned WDOG_WIDTH    = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     cmd_valid_i,
    input  logic [1:0]               cmd_op_i,
    input  logic [COUNTER_WIDTH-1:0] cmd_count_i,
    input  logic [MESHES-1:0]        cmd_mask_i,
    input  logic [WDOG_WIDTH-1:0]    wdog_limit_i,
    input  logic [MESHES-1:0]        idle_i,
    output logic [MESHES-1:0]        trigger_o,
    output logic [COUNTER_WIDTH-1:0] counter_o,
    output logic                     running_o,
    output logic                     done_o,
    output logic                     wrap_o,
    output logic                     error_o
);

    nx_state_e state_q, state_d;
    nx_mode_e  mode_q, mode_d;

    logic [MESHES-1:0]        mask_q, mask_d;
    logic [COUNTER_WIDTH-1:0] remaining_q, remaining_d;
    logic [COUNTER_WIDTH-1:0] counter_q, counter_d;
    logic [MESHES-1:0]        trigger_q, trigger_d;
    logic                     stop_pend_q, stop_pend_d;
    logic                     wrap_q, wrap_d;
    logic                     done_q, done_d;

    nx_op_e op;
    logic   all_idle;
    logic   start_ok;
    logic   accept;
    logic   stop_req;
    logic   drain;
    logic   fire;
    logic   finish;
    logic   timeout;

    assign op       = nx_op_e'(cmd_op_i);
    // Unmasked meshes never hold the sequencer back.
    assign all_idle = &(idle_i | ~mask_q);
    assign start_ok = cmd_valid_i && nx_is_start(op) && (cmd_mask_i != '0) &&
                      ((op == NX_CTRL_RUN) || (cmd_count_i != '0));
    assign accept   = (state_q == StStop) && start_ok;
    assign stop_req = cmd_valid_i && (op == NX_CTRL_STOP) && (state_q != StStop);
    assign drain    = stop_pend_q || ((mode_q == ModeStep) && (remaining_q == '0));

`ifdef NX_SIM_CTRL_WDOG_EN
    logic wdog_clear;
    logic wdog_enable;
    logic error_q, error_d;

    assign wdog_clear  = fire || accept;
    assign wdog_enable = (state_q != StStop);

    nx_ctrl_watchdog #(
        .WDOG_WIDTH(WDOG_WIDTH)
    ) u_wdog (
        .clk    (clk_i),
        .rst_n  (rst_i),
        .clear  (wdog_clear),
        .enable (wdog_enable),
        .limit  (wdog_limit_i),
        .timeout(timeout)
    );

    always_comb begin
        error_d = error_q;
        if (timeout) begin
            error_d = 1'b1;
        end else if (accept) begin
            error_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign error_o = error_q;
`else
    logic unused_wdog_limit;

    assign unused_wdog_limit = ^wdog_limit_i;
    assign timeout           = 1'b0;
    assign error_o           = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StStop;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; also decides the per-cycle fire/finish events.
    always_comb begin
        state_d = state_q;
        fire    = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            StStop: begin
                if (accept) begin
                    state_d = StWaitIdle;
                end
            end
            StWaitIdle: begin
                if (timeout || (all_idle && drain)) begin
                    finish  = 1'b1;
                    state_d = StStop;
                end else if (all_idle) begin
                    fire    = 1'b1;
                    state_d = StWaitBusy;
                end
            end
            StWaitBusy: begin
                if (timeout) begin
                    finish  = 1'b1;
                    state_d = StStop;
                end else if (!all_idle) begin
                    state_d = StWaitIdle;
                end
            end
            default: state_d = StStop;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        mask_d      = mask_q;
        mode_d      = mode_q;
        remaining_d = remaining_q;
        counter_d   = counter_q;
        wrap_d      = wrap_q;
        stop_pend_d = stop_pend_q;
        trigger_d   = '0;
        done_d      = finish;

        if (accept) begin
            mask_d      = cmd_mask_i;
            mode_d      = (op == NX_CTRL_STEP) ? ModeStep : ModeRun;
            remaining_d = (op == NX_CTRL_STEP) ? cmd_count_i : '0;
        end

        if (fire) begin
            trigger_d = mask_q;
            counter_d = counter_q + COUNTER_WIDTH'(1);
            wrap_d    = wrap_q | (&counter_q);
            if (mode_q == ModeStep) begin
                remaining_d = remaining_q - COUNTER_WIDTH'(1);
            end
        end

        if (finish) begin
            stop_pend_d = 1'b0;
        end else if (stop_req) begin
            stop_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mode_q      <= ModeRun;
            mask_q      <= '0;
            remaining_q <= '0;
            counter_q   <= '0;
            wrap_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            trigger_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            mask_q      <= mask_d;
            remaining_q <= remaining_d;
            counter_q   <= counter_d;
            wrap_q      <= wrap_d;
            stop_pend_q <= stop_pend_d;
            trigger_q   <= trigger_d;
            done_q      <= done_d;
        end
    end

    assign trigger_o = trigger_q;
    assign counter_o = counter_q;
    assign running_o = (state_q != StStop);
    assign done_o    = done_q;
    assign wrap_o    = wrap_q;

endmodule

// File: tb/tb_nx_sim_ctrl.sv
// Self-checking bench for nx_sim_ctrl with reactive mesh models and a transaction-level model.
// Also exercises the watchdog path when built with NX_SIM_CTRL_WDOG_EN.
module tb_nx_sim_ctrl;
    import nx_ctrl_pkg::*;

    localparam int unsigned M  = 4;
    localparam int unsigned CW = 6;
    localparam int unsigned WW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic [1:0]    cmd_op;
    logic [CW-1:0] cmd_count;
    logic [M-1:0]  cmd_mask;
    logic [WW-1:0] wdog_limit;
    logic [M-1:0]  idle;
    logic [M-1:0]  trigger;
    logic [CW-1:0] counter;
    logic          running;
    logic          done;
    logic          wrap;
    logic          error;

    always #5 clk = ~clk;

    nx_sim_ctrl #(
        .MESHES       (M),
        .COUNTER_WIDTH(CW),
        .WDOG_WIDTH   (WW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_op_i    (cmd_op),
        .cmd_count_i (cmd_count),
        .cmd_mask_i  (cmd_mask),
        .wdog_limit_i(wdog_limit),
        .idle_i      (idle),
        .trigger_o   (trigger),
        .counter_o   (counter),
        .running_o   (running),
        .done_o      (done),
        .wrap_o      (wrap),
        .error_o     (error)
    );

    int checks = 0;
    int errors = 0;

    // Transaction-level model state.
    logic [M-1:0] exp_mask;
    int           exp_cnt;
    bit           exp_wrap;
    int           trig_count;
    int           done_count;
    int           since_trig;
    int           m2_pulses;
    bit           prev_all_idle;

    // Mesh models: react clocks after a trigger, then busy for blen clocks.
    int           dly [M];
    int           bsy [M];
    int           react;
    int           blen;
    logic [M-1:0] hold;
    logic [M-1:0] deaf;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic reset_models();
        exp_cnt       = 0;
        exp_wrap      = 0;
        exp_mask      = '0;
        hold          = '0;
        deaf          = '0;
        idle          = '1;
        prev_all_idle = 1'b1;
        since_trig    = 99;
        for (int i = 0; i < M; i++) begin
            dly[i] = 0;
            bsy[i] = 0;
        end
    endtask

    task automatic mesh_step();
        for (int i = 0; i < M; i++) begin
            if (trigger[i] && !deaf[i]) begin
                dly[i] = react;
            end else if (dly[i] > 0) begin
                dly[i]--;
                if (dly[i] == 0) bsy[i] = blen;
            end else if (bsy[i] > 0) begin
                bsy[i]--;
            end
            idle[i] = (bsy[i] == 0) && !hold[i];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (trigger !== '0) begin
            check("trig_value", trigger, exp_mask);
            check("trig_after_all_idle", prev_all_idle, 1);
            check("trig_spacing", since_trig >= 2, 1);
            trig_count++;
            if (trigger[2]) m2_pulses++;
            since_trig = 0;
            exp_cnt    = (exp_cnt + 1) % (1 << CW);
            if (exp_cnt == 0) exp_wrap = 1;
        end else begin
            since_trig++;
        end
        if (done) begin
            done_count++;
            check("done_after_all_idle", prev_all_idle, 1);
        end
        mesh_step();
        prev_all_idle = &(idle | ~exp_mask);
    endtask

    task automatic send(input logic [1:0] op, input logic [CW-1:0] cnt, input logic [M-1:0] msk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_count = cnt;
        cmd_mask  = msk;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = NX_CTRL_NOP;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n;
        int d0;
        n  = 0;
        d0 = done_count;
        while (done_count == d0 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_finished"}, done_count != d0, 1);
    endtask

    task automatic run_step(input int cnt, input logic [M-1:0] msk, input string tag);
        int t0;
        int d0;
        t0       = trig_count;
        d0       = done_count;
        exp_mask = msk;
        send(NX_CTRL_STEP, CW'(cnt), msk);
        check({tag, "_running"}, running, 1);
        wait_done(cnt * 20 + 50, tag);
        check({tag, "_trigs"}, trig_count - t0, cnt);
        check({tag, "_counter"}, counter, exp_cnt);
        check({tag, "_done_count"}, done_count - d0, 1);
        check({tag, "_stopped"}, running, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int t0;
        int d0;
        int n;
        int need;
        int cnt;
        logic [M-1:0] msk;

        cmd_valid  = 1'b0;
        cmd_op     = NX_CTRL_NOP;
        cmd_count  = '0;
        cmd_mask   = '0;
        wdog_limit = '0;
        rst_n      = 1'b0;
        react      = 2;
        blen       = 4;
        trig_count = 0;
        done_count = 0;
        m2_pulses  = 0;
        reset_models();

        repeat (3) @(posedge clk);
        #1;
        check("rst_trigger", trigger, 0);
        check("rst_counter", counter, 0);
        check("rst_running", running, 0);
        check("rst_done", done, 0);
        check("rst_wrap", wrap, 0);
        check("rst_error", error, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // STEP 3 on meshes 0 and 1.
        react = 2;
        blen  = 4;
        run_step(3, 4'b0011, "step3");
        check("step3_counter_abs", counter, 3);
        d0 = done_count;
        repeat (5) tick();
        check("step3_single_done", done_count - d0, 0);

        // RUN on mesh 0, STOP after the fifth trigger while the mesh is busy.
        exp_mask = 4'b0001;
        t0       = trig_count;
        d0       = done_count;
        send(NX_CTRL_RUN, '0, 4'b0001);
        n = 0;
        while (trig_count - t0 < 5 && n < 300) begin
            tick();
            n++;
        end
        check("run_five_trigs", trig_count - t0, 5);
        n = 0;
        while (idle[0] && n < 20) begin
            tick();
            n++;
        end
        check("run_mesh_busy", idle[0], 0);
        send(NX_CTRL_STOP, '0, '0);
        check("run_draining", running, 1);
        send(NX_CTRL_STOP, '0, '0);
        wait_done(100, "run_stop");
        check("run_stop_trigs", trig_count - t0, 5);
        check("run_stop_counter", counter, exp_cnt);
        check("run_stop_done_count", done_count - d0, 1);
        check("run_stop_stopped", running, 0);

        // Unmasked mesh 2 held busy must neither block nor be triggered.
        hold      = 4'b0100;
        idle      = 4'b1011;
        m2_pulses = 0;
        react     = 2;
        blen      = 2;
        run_step(4, 4'b0011, "mesh2");
        check("mesh2_never_pulsed", m2_pulses, 0);
        hold = '0;
        idle = '1;
        tick();

        // Randomised STEP transactions.
        for (int it = 0; it < 8; it++) begin
            react = int'($urandom_range(1, 3));
            blen  = int'($urandom_range(1, 5));
            msk   = M'($urandom_range(1, (1 << M) - 1));
            cnt   = int'($urandom_range(1, 6));
            hold  = M'($urandom) & ~msk;
            idle  = ~hold;
            tick();
            run_step(cnt, msk, "rand");
        end
        hold = '0;
        idle = '1;
        tick();

        // Drive the counter through all-ones.
        check("wrap_before", wrap, exp_wrap);
        react = 1;
        blen  = 1;
        need  = (1 << CW) - exp_cnt;
        if (need == (1 << CW)) begin
            run_step((1 << CW) - 1, 4'b1111, "wrap_pre");
            need = 1;
        end
        run_step(need, 4'b1111, "wrap");
        check("wrap_counter_zero", counter, 0);
        check("wrap_set", wrap, 1);
        run_step(2, 4'b0101, "wrap_sticky");
        check("wrap_still_set", wrap, 1);

        // Meshes never react: sequencer must park waiting for busy.
        deaf     = '1;
        exp_mask = 4'b0001;
`ifdef NX_SIM_CTRL_WDOG_EN
        wdog_limit = 8'd10;
`endif
        t0 = trig_count;
        d0 = done_count;
        send(NX_CTRL_RUN, '0, 4'b0001);
        n = 0;
        while (trig_count - t0 < 1 && n < 20) begin
            tick();
            n++;
        end
        check("stuck_first_trig", trig_count - t0, 1);
`ifdef NX_SIM_CTRL_WDOG_EN
        wait_done(40, "wdog");
        check("wdog_error", error, 1);
        check("wdog_stopped", running, 0);
        check("wdog_trigs", trig_count - t0, 1);
        wdog_limit = '0;
        deaf       = '0;
        exp_mask   = 4'b0011;
        send(NX_CTRL_RUN, '0, 4'b0011);
        check("wdog_error_clear", error, 0);
        repeat (10) tick();
`else
        repeat (20) tick();
        check("stuck_no_second_trig", trig_count - t0, 1);
        check("stuck_running", running, 1);
        send(NX_CTRL_RUN, '0, 4'b0110);
        repeat (3) tick();
        send(NX_CTRL_STOP, '0, '0);
        repeat (10) tick();
        check("stuck_stop_running", running, 1);
        check("stuck_no_done", done_count - d0, 0);
        check("stuck_trigs", trig_count - t0, 1);
        check("stuck_error_low", error, 0);
`endif

        // Asynchronous reset mid-run.
        check("pre_reset_running", running, 1);
        #3 rst_n = 1'b0;
        #1;
        check("arst_trigger", trigger, 0);
        check("arst_counter", counter, 0);
        check("arst_running", running, 0);
        check("arst_done", done, 0);
        check("arst_wrap", wrap, 0);
        check("arst_error", error, 0);
        reset_models();
        react = 2;
        blen  = 2;
        d0    = done_count;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        check("arst_no_done", done_count - d0, 0);

        // Commands that must be ignored while stopped.
        t0 = trig_count;
        d0 = done_count;
        send(NX_CTRL_STEP, '0, 4'b0011);
        repeat (4) tick();
        check("step0_ignored", running, 0);
        send(NX_CTRL_RUN, 6'd5, 4'b0000);
        repeat (4) tick();
        check("mask0_ignored", running, 0);
        send(NX_CTRL_STOP, '0, '0);
        repeat (3) tick();
        check("ignored_no_trigs", trig_count - t0, 0);
        check("ignored_no_done", done_count - d0, 0);
        check("ignored_counter", counter, exp_cnt);

        run_step(2, 4'b1000, "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
